// File: rtl/clock_edge_pkg.sv
// Shared types and helpers for the external clock edge recovery block.
package clock_edge_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TRACK   = 2'd2,
        LOCKED  = 2'd3
    } edge_state_t;

    // All-ones value of a counter of the given width (the saturation point).
    function automatic logic [31:0] sat_value(input int width);
        return 32'((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Brings an asynchronous slow clock into the clk domain and flags its edges.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_in,
    output logic rec_clk,
    output logic rising_edge,
    output logic falling_edge
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain followed by one flop remembering the previous level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rec_clk      = sync_q[SYNC_STAGES-1];
    assign rising_edge  = rec_clk & ~prev_q;
    assign falling_edge = ~rec_clk & prev_q;

endmodule

// File: rtl/clock_edge_recover.sv
// Recovers edge strobes from an external slow clock, measures its period
// in clk cycles and reports when successive periods agree (lock).
module clock_edge_recover
    import clock_edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int LOCK_COUNT  = 4,
    parameter int TOL         = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_in,
    output logic             rec_clk,
    output logic             rising_edge,
    output logic             falling_edge,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost
);

    localparam int               MW          = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(sat_value(CNT_W));
    localparam logic [MW-1:0]    LOCK_TARGET = MW'(LOCK_COUNT);
    localparam logic [CNT_W:0]   TOL_W       = (CNT_W + 1)'(TOL);

    edge_state_t             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        period_q, period_d;
    logic [MW-1:0]           match_q, match_d;
    logic [MW-1:0]           match_inc;
    logic                    valid_q, valid_d;
    logic                    lost_q, lost_d;
    logic signed [CNT_W:0]   diff;
    logic [CNT_W:0]          abs_diff;
    logic                    in_tol;
    logic                    cnt_sat;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk         (clk),
        .rst         (rst),
        .clk_in      (clk_in),
        .rec_clk     (rec_clk),
        .rising_edge (rising_edge),
        .falling_edge(falling_edge)
    );

    // The running count is the candidate period; compare it with the last capture.
    assign diff      = $signed({1'b0, cnt_q}) - $signed({1'b0, period_q});
    assign abs_diff  = (diff < 0) ? $unsigned(-diff) : $unsigned(diff);
    assign in_tol    = (abs_diff <= TOL_W);
    assign cnt_sat   = (cnt_q == CNT_MAX);
    assign match_inc = match_q + MW'(1);

    // Next-state, capture and strobe decisions; a rising edge beats a timeout.
    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        period_d = period_q;
        valid_d  = 1'b0;
        lost_d   = 1'b0;
        cnt_d    = cnt_sat ? cnt_q : cnt_q + CNT_W'(1);

        if (rising_edge) begin
            cnt_d = CNT_W'(1);
            case (state_q)
                IDLE: begin
                    state_d = MEASURE;
                end
                MEASURE: begin
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                    match_d  = '0;
                    state_d  = TRACK;
                end
                TRACK: begin
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                    if (in_tol) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_TARGET) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                    if (!in_tol) begin
                        match_d = '0;
                        lost_d  = 1'b1;
                        state_d = TRACK;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else if (cnt_sat && (state_q != IDLE)) begin
            lost_d  = (state_q == LOCKED);
            match_d = '0;
            state_d = IDLE;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            match_q  <= '0;
            valid_q  <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            match_q  <= match_d;
            valid_q  <= valid_d;
            lost_q   <= lost_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign lost         = lost_q;
    assign locked       = (state_q == LOCKED);

endmodule

// File: tb/tb_clock_edge_recover.sv
// Bench for clock_edge_recover: timestamp-based reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_clock_edge_recover;

    localparam int SYNC = 2;
    localparam int CW   = 10;
    localparam int LC   = 4;
    localparam int TOLV = 2;
    localparam int MAXV = 1023;

    localparam int S_IDLE   = 0;
    localparam int S_MEAS   = 1;
    localparam int S_TRACK  = 2;
    localparam int S_LOCKED = 3;

    logic          clk;
    logic          rst;
    logic          clk_in;
    logic          rec_clk;
    logic          rising_edge;
    logic          falling_edge;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          locked;
    logic          lost;
    logic [15:0]   outs;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic hist[$];
    int   m_state     = S_IDLE;
    int   m_streak    = 0;
    int   m_period    = 0;
    int   last_strobe = 0;
    logic e_rec   = 1'b0;
    logic e_rise  = 1'b0;
    logic e_fall  = 1'b0;
    logic e_valid = 1'b0;
    logic e_lost  = 1'b0;

    int n_lost        = 0;
    int n_unlock      = 0;
    int n_valid       = 0;
    int last_rise_cyc = 0;
    int last_lost_cyc = 0;
    int str_first     = 0;
    int str_width     = 0;

    clock_edge_recover #(
        .SYNC_STAGES(SYNC),
        .CNT_W      (CW),
        .LOCK_COUNT (LC),
        .TOL        (TOLV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_in      (clk_in),
        .rec_clk     (rec_clk),
        .rising_edge (rising_edge),
        .falling_edge(falling_edge),
        .period      (period),
        .period_valid(period_valid),
        .locked      (locked),
        .lost        (lost)
    );

    assign outs = {rec_clk, rising_edge, falling_edge, period_valid, locked, lost, period};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: input levels seen at each edge, strobe timestamps and
    // the lock rules applied to the gaps between successive rising strobes.
    always @(posedge clk) begin : model
        int gap;
        int dev;
        cyc = cyc + 1;
        if (rst) begin
            hist.delete();
            for (int i = 0; i <= SYNC; i++) hist.push_front(1'b0);
            m_state = S_IDLE; m_streak = 0; m_period = 0; last_strobe = 0;
            e_rec = 1'b0; e_rise = 1'b0; e_fall = 1'b0; e_valid = 1'b0; e_lost = 1'b0;
        end else begin
            e_valid = 1'b0;
            e_lost  = 1'b0;
            if (e_rise) begin
                gap = (cyc - 1) - last_strobe;
                if (gap > MAXV) gap = MAXV;
                last_strobe = cyc - 1;
                if (m_state == S_IDLE) begin
                    m_state = S_MEAS;
                end else if (m_state == S_MEAS) begin
                    m_period = gap; e_valid = 1'b1; m_state = S_TRACK; m_streak = 0;
                end else begin
                    dev = gap - m_period;
                    if (dev < 0) dev = -dev;
                    m_period = gap;
                    e_valid  = 1'b1;
                    if (m_state == S_TRACK) begin
                        if (dev <= TOLV) begin
                            m_streak = m_streak + 1;
                            if (m_streak == LC) m_state = S_LOCKED;
                        end else begin
                            m_streak = 0;
                        end
                    end else if (dev > TOLV) begin
                        m_state = S_TRACK; m_streak = 0; e_lost = 1'b1;
                    end
                end
            end else if (m_state != S_IDLE && (cyc - 1) - last_strobe >= MAXV) begin
                e_lost   = (m_state == S_LOCKED);
                m_state  = S_IDLE;
                m_streak = 0;
            end
            hist.push_front(clk_in);
            if (hist.size() > SYNC + 1) void'(hist.pop_back());
            e_rec  = hist[SYNC-1];
            e_rise = hist[SYNC-1] & ~hist[SYNC];
            e_fall = ~hist[SYNC-1] & hist[SYNC];
        end
    end

    // Every cycle, all outputs against the model (all zero while in reset).
    always @(negedge clk) begin : compare
        logic [15:0] want;
        if (rst) want = '0;
        else     want = {e_rec, e_rise, e_fall, e_valid, (m_state == S_LOCKED), e_lost, CW'(m_period)};
        checks = checks + 1;
        if (outs !== want) begin
            errors = errors + 1;
            $display("[TB] FAIL cycle %0d outputs: got %h expected %h", cyc, outs, want);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks = checks + 1;
        if (actual != expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (lost) begin
            n_lost = n_lost + 1;
            last_lost_cyc = cyc;
        end
        if (!locked) n_unlock = n_unlock + 1;
        if (period_valid) n_valid = n_valid + 1;
        if (rising_edge) last_rise_cyc = cyc;
    endtask

    task automatic applyStimulus(input logic level, input int len, input bit expect_edge, input string tag);
        clk_in    = level;
        str_first = -1;
        str_width = 0;
        for (int i = 1; i <= len; i++) begin
            tick();
            if (level ? rising_edge : falling_edge) begin
                if (str_first < 0) str_first = i;
                str_width = str_width + 1;
            end
        end
        if (expect_edge) begin
            checkOutput({tag, " latency"}, str_first, SYNC);
            checkOutput({tag, " width"}, str_width, 1);
        end else begin
            checkOutput({tag, " no strobe"}, str_width, 0);
        end
    endtask

    task automatic fullPeriod(input int hi, input int lo);
        applyStimulus(1'b1, hi, 1'b1, "rise");
        applyStimulus(1'b0, lo, 1'b1, "fall");
    endtask

    initial begin
        clk_in = 1'b0;
        rst    = 1'b0;
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("reset outputs", int'(outs), 0);
        rst = 1'b0;

        applyStimulus(1'b0, 20, 1'b0, "idle");
        checkOutput("idle outputs", int'(outs), 0);
        checkOutput("idle valid count", n_valid, 0);
        checkOutput("idle lost count", n_lost, 0);

        $display("[TB] steady input, period 256");
        n_valid = 0;
        for (int k = 1; k <= 8; k++) begin
            fullPeriod(128, 128);
            if (k == 1) checkOutput("valid after strobe 1", n_valid, 0);
            if (k == 2) begin
                checkOutput("period after strobe 2", int'(period), 256);
                checkOutput("valid after strobe 2", n_valid, 1);
            end
            if (k == 5) checkOutput("locked after strobe 5", int'(locked), 0);
            if (k == 6) checkOutput("locked after strobe 6", int'(locked), 1);
        end

        $display("[TB] one stretched period of 262");
        n_lost = 0;
        fullPeriod(131, 131);
        fullPeriod(128, 128);
        checkOutput("stretch period", int'(period), 262);
        checkOutput("stretch lost count", n_lost, 1);
        checkOutput("stretch locked", int'(locked), 0);
        for (int k = 1; k <= 5; k++) begin
            fullPeriod(128, 128);
            if (k == 4) checkOutput("relock after 4 periods", int'(locked), 0);
            if (k == 5) checkOutput("relock after 5 periods", int'(locked), 1);
        end

        $display("[TB] jitter of one cycle while locked");
        n_lost   = 0;
        n_unlock = 0;
        for (int k = 1; k <= 3; k++) begin
            fullPeriod(129, 128);
            fullPeriod(127, 128);
        end
        fullPeriod(128, 128);
        checkOutput("jitter unlocked cycles", n_unlock, 0);
        checkOutput("jitter lost count", n_lost, 0);
        checkOutput("jitter last period", int'(period), 255);
        fullPeriod(128, 128);
        checkOutput("period before stop", int'(period), 256);

        $display("[TB] input stopped while locked");
        n_lost  = 0;
        n_valid = 0;
        applyStimulus(1'b0, 1100, 1'b0, "stopped");
        checkOutput("timeout lost count", n_lost, 1);
        checkOutput("timeout gap", last_lost_cyc - last_rise_cyc, MAXV + 1);
        checkOutput("timeout locked", int'(locked), 0);
        checkOutput("timeout period held", int'(period), 256);
        checkOutput("timeout valid count", n_valid, 0);

        for (int k = 1; k <= 7; k++) fullPeriod(128, 128);
        checkOutput("locked after restart", int'(locked), 1);

        $display("[TB] reset while locked with clk_in high");
        applyStimulus(1'b1, 50, 1'b1, "rise before reset");
        rst = 1'b1;
        #1;
        checkOutput("reset clears outputs", int'(outs), 0);
        repeat (3) tick();
        rst = 1'b0;
        str_first = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (rising_edge && str_first < 0) str_first = i;
        end
        checkOutput("rise after reset release", str_first, SYNC);
        applyStimulus(1'b0, 128, 1'b1, "fall");
        for (int k = 1; k <= 7; k++) fullPeriod(128, 128);
        checkOutput("locked after reset recovery", int'(locked), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_edge_recover.md
# clock_edge_recover

Receive-side counterpart of the clock divider. It takes an externally generated slow clock (for example an I2S BCLK/LRCLK from a codec or another board) and synchronizes it into the fast `clk` domain. It then produces one-cycle rising and falling edge strobes, measures the input period in `clk` cycles and reports frequency lock. Downstream audio logic consumes these strobes exactly as it consumes the divider's strobes, whether the slow clock is generated locally or externally.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops; minimum 2.
- `CNT_W`, default 16: period counter and `period` width.
- `LOCK_COUNT`, default 4: consecutive matching period comparisons required for lock; minimum 1.
- `TOL`, default 2: allowed absolute difference, in `clk` cycles, between successive periods.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `clk_in`  in  1  external slow clock, asynchronous to `clk`.
- `rec_clk`  out  1  synchronized level of `clk_in`.
- `rising_edge`  out  1  one-cycle strobe per detected 0→1 of `rec_clk`.
- `falling_edge`  out  1  one-cycle strobe per detected 1→0 of `rec_clk`.
- `period`  out  CNT_W  `clk` cycles between the last two `rising_edge` strobes.
- `period_valid`  out  1  one-cycle strobe; `period` was updated.
- `locked`  out  1  high while in LOCKED.
- `lost`  out  1  one-cycle strobe when leaving LOCKED.

## Operation
- **Synchronizer.** `clk_in` passes through SYNC_STAGES flops. The last stage drives `rec_clk`. One further flop, `prev`, holds the previous value of `rec_clk`.
  - `rising_edge` = `rec_clk & ~prev`.
  - `falling_edge` = `~rec_clk & prev`.
  - The two strobes are never high together.
- **Counter.** Increments every cycle and saturates at 2^CNT_W−1. It restarts on each `rising_edge`, so `period` equals the cycle distance between strobes. Strobes at cycles 10 and 266 give `period` = 256.
- **FSM, from package enum.** Transitions are evaluated on `rising_edge`:
  - **IDLE:** no edge seen. `rising_edge` → MEASURE.
  - **MEASURE:** next `rising_edge` → capture `period`, pulse `period_valid`, go to TRACK with match_cnt = 0.
  - **TRACK:** each `rising_edge` captures the new period and pulses `period_valid`.
    - If |new − old| ≤ TOL, match_cnt increments; otherwise match_cnt is cleared.
    - When match_cnt reaches LOCK_COUNT → LOCKED.
  - **LOCKED:** each `rising_edge` captures and pulses `period_valid`. A deviation greater than TOL → TRACK with match_cnt = 0, and `lost` is pulsed.
  - **Timeout:** counter saturated with no `rising_edge` that cycle, in any state other than IDLE → IDLE. `lost` is pulsed if the block was LOCKED. `period` holds its value and no `period_valid` is generated.
- **Arithmetic.** The difference is computed in CNT_W+1 bits, signed, then its absolute value is taken. The comparison uses the previous captured `period`.
- **Simultaneous events.** When `rising_edge` coincides with counter saturation, the edge wins: `period` = 2^CNT_W−1 and no timeout occurs.
- **Input constraints.** `clk_in` must stay high and low for at least SYNC_STAGES+1 `clk` cycles each. Shorter pulses may be missed, and that is not an error.

## Timing
- **Reset values.** All flops are cleared, including the synchronizer and `prev`. All outputs are 0 and the state is IDLE.
- **Strobe latency.** `rising_edge` and `falling_edge` go high for exactly one cycle, following the SYNC_STAGES-th `clk` edge at which the new `clk_in` level is sampled. Latency is the same for both polarities.
- **Capture timing.** `period`, `period_valid`, `locked` and `lost` are registered. They update on the `clk` edge that ends the `rising_edge` cycle.
- **Time to lock.** At constant input period, `locked` rises after the (LOCK_COUNT+2)-th rising strobe. With defaults that is the 6th strobe.
- **Reset mid-operation.** Returns the block to the reset values immediately.
  - If `clk_in` is high at reset release, a `rising_edge` occurs SYNC_STAGES cycles later and is treated as a real edge.
  - The resulting first period may be partial. The block recovers through TRACK with no special handling.

## Structure
- Package `clock_edge_pkg` holds:
  - `typedef enum` for IDLE, MEASURE, TRACK, LOCKED;
  - the saturation constant helper.
- Sub-module `sync_edge`: SYNC_STAGES synchronizer plus `prev` flop. It outputs `rec_clk`, `rising_edge` and `falling_edge`.
- The top level holds the counter, the period and comparison logic, and the FSM.

## Test plan
- Reset with `clk_in` = 0, then release: every output is 0 and stays 0 while no edges occur.
- `clk_in` toggles every 128 `clk` cycles (period 256):
  - `rising_edge`/`falling_edge` are one cycle wide, SYNC_STAGES cycles after each transition;
  - `period` = 256 with `period_valid` from the 2nd rising strobe;
  - `locked` = 1 after the 6th rising strobe.
- While locked, stretch one period to 262 (deviation 6 > TOL): `lost` pulses, `locked` drops, then relocks after 4 further matching periods.
- Jitter of ±1 cycle around 256 (deviation ≤ TOL) while locked: `locked` never drops.
- Stop `clk_in` while locked with CNT_W = 10: after 1023 cycles without an edge, `lost` pulses, the state returns to IDLE and `period` is unchanged.
- Assert `rst` mid-lock with `clk_in` high, then release:
  - all outputs clear immediately;
  - a `rising_edge` occurs SYNC_STAGES cycles after release;
  - the block relocks on subsequent stable input.
